// File: rtl/frontend_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// frontend_hazard_ctrl_pkg
// Shared definitions for the front-end sequencer:
//   - FE_IDLE / FE_FETCH / FE_DISCARD : state encodings (3 is unused)
//   - FE_NOP                          : instruction word loaded by an IF/ID flush
//   - REG_AW_DEFAULT                  : default register-index width
//   - fe_state_e                      : FSM state type built on the encodings
// ----------------------------------------------------------------------------
package frontend_hazard_ctrl_pkg;

    localparam logic [1:0]  FE_IDLE    = 2'd0;
    localparam logic [1:0]  FE_FETCH   = 2'd1;
    localparam logic [1:0]  FE_DISCARD = 2'd2;

    localparam logic [31:0] FE_NOP     = 32'h0000_0013;

    localparam int unsigned REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        StIdle    = FE_IDLE,
        StFetch   = FE_FETCH,
        StDiscard = FE_DISCARD
    } fe_state_e;

endpackage

// File: rtl/frontend_hazard_detect.sv
// ----------------------------------------------------------------------------
// frontend_hazard_detect
// Combinational load-use compare between the load in EX and the sources of
// the instruction in ID. Register x0 never creates a dependency.
// Ports:
//   id_valid, id_rs1, id_rs2        : ID stage instruction and its sources
//   ex_valid, ex_mem_read, ex_rd    : EX stage instruction, load flag, dest
//   load_use                        : ID must stall one cycle behind the load
// ----------------------------------------------------------------------------
module frontend_hazard_detect
    import frontend_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    logic rd_nonzero;
    logic src_match;

    assign rd_nonzero = (ex_rd != '0);
    assign src_match  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign load_use   = ex_valid && ex_mem_read && rd_nonzero && id_valid && src_match;

endmodule

// File: rtl/frontend_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// frontend_hazard_ctrl
// Front-end sequencer: owns the instruction-memory request handshake, stalls
// on load-use hazards, applies branch redirects and discards a fetch that a
// redirect made stale. All outputs are Mealy functions of state and inputs.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req / imem_ready : fetch request (held until ready) / data valid
//   id_*, ex_*            : operands for the load-use compare
//   branch_taken          : EX resolved a taken branch/jump
//   pc_enable, pc_redirect: PC update strobe / PC mux selects target
//   if_id_enable/flush    : IF/ID load strobe / load NOP with valid=0
//   if_id_valid_in        : valid bit presented to IF/ID
//   id_ex_flush           : bubble into ID/EX
//   ctrl_state            : current state (debug)
//   stall_cycles, redirect_count : saturating counters, only with
//                           FRONTEND_PERF_CNT_EN defined
// ----------------------------------------------------------------------------
module frontend_hazard_ctrl
    import frontend_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    output logic              pc_enable,
    output logic              pc_redirect,
    output logic              if_id_enable,
    output logic              if_id_flush,
    output logic              if_id_valid_in,
    output logic              id_ex_flush,
`ifdef FRONTEND_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       redirect_count,
`endif
    output logic [1:0]        ctrl_state
);

    fe_state_e state_q, state_d;
    logic      load_use;

    frontend_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        imem_req       = 1'b0;
        pc_enable      = 1'b0;
        pc_redirect    = 1'b0;
        if_id_enable   = 1'b0;
        if_id_flush    = 1'b0;
        if_id_valid_in = 1'b0;
        id_ex_flush    = 1'b0;

        case (state_q)
            // No request in IDLE; imem_ready is ignored here.
            StIdle: begin
                state_d = StFetch;
            end

            StFetch: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_redirect = 1'b1;
                    pc_enable   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    // An outstanding request now returns a stale word.
                    if (!imem_ready) begin
                        state_d = StDiscard;
                    end
                end else if (load_use) begin
                    // Hold PC so the same address is re-requested next cycle.
                    id_ex_flush = 1'b1;
                end else if (imem_ready) begin
                    pc_enable      = 1'b1;
                    if_id_enable   = 1'b1;
                    if_id_valid_in = 1'b1;
                end else begin
                    // Memory wait: bubble into ID.
                    if_id_enable = 1'b1;
                end
            end

            StDiscard: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_redirect = 1'b1;
                    pc_enable   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    if_id_enable = 1'b1;
                    if (imem_ready) begin
                        state_d = StFetch;
                    end
                end
            end

            // Unused encoding recovers to IDLE.
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ctrl_state = state_q;

`ifdef FRONTEND_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] redirect_count_q;
    logic        stall_event;

    assign stall_event = imem_req && !pc_enable && !pc_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            if (stall_event && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (pc_redirect && (redirect_count_q != '1)) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_frontend_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frontend_hazard_ctrl
// Directed scenarios followed by randomized traffic. A behavioural model
// (flags "fetching" and "stale word pending") predicts every cycle's outputs,
// pushes them into a queue; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_frontend_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req, imem_ready;
    logic          id_valid, ex_valid, ex_mem_read, branch_taken;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          pc_enable, pc_redirect, if_id_enable, if_id_flush;
    logic          if_id_valid_in, id_ex_flush;
    logic [1:0]    ctrl_state;
`ifdef FRONTEND_PERF_CNT_EN
    logic [31:0]   stall_cycles, redirect_count;
`endif

    frontend_hazard_ctrl #(
        .REG_AW (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .branch_taken   (branch_taken),
        .pc_enable      (pc_enable),
        .pc_redirect    (pc_redirect),
        .if_id_enable   (if_id_enable),
        .if_id_flush    (if_id_flush),
        .if_id_valid_in (if_id_valid_in),
        .id_ex_flush    (id_ex_flush),
`ifdef FRONTEND_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count),
`endif
        .ctrl_state     (ctrl_state)
    );

    always #5 clk = ~clk;

    // {req, pce, redir, ifen, iflush, ivalid, idflush, state[1:0]}
    typedef logic [8:0] outv_t;

    outv_t       exp_q[$];
    logic [63:0] exp_cnt_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    // Reference model state
    bit          m_fetching;
    bit          m_stale;
    logic [31:0] m_stall, m_redir;

    task automatic step(input bit rst, input bit rdy, input bit idv,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input bit exv, input bit mr, input logic [AW-1:0] rd,
                        input bit br);
        bit    req, pce, redir, ifen, iflush, ivalid, idflush, hazard;
        int    st;
        @(posedge clk);
        #1;
        rst_n = rst; imem_ready = rdy; id_valid = idv; id_rs1 = rs1; id_rs2 = rs2;
        ex_valid = exv; ex_mem_read = mr; ex_rd = rd; branch_taken = br;
        cyc++;

        {req, pce, redir, ifen, iflush, ivalid, idflush} = '0;
        st = 0;
        hazard = exv && mr && (rd != 0) && idv && (rd == rs1 || rd == rs2);

        if (!rst) begin
            m_fetching = 0; m_stale = 0; m_stall = 0; m_redir = 0;
        end else if (!m_fetching) begin
            m_fetching = 1;
        end else begin
            st  = m_stale ? 2 : 1;
            req = 1;
            if (br) begin
                redir = 1; pce = 1; iflush = 1; idflush = 1;
                // a fresh redirect while a word is outstanding makes it stale
                m_stale = m_stale ? 1'b1 : !rdy;
            end else if (m_stale) begin
                ifen = 1;
                if (rdy) m_stale = 0;
            end else if (hazard) begin
                idflush = 1;
            end else begin
                ifen = 1; pce = rdy; ivalid = rdy;
            end
        end

        exp_q.push_back({req, pce, redir, ifen, iflush, ivalid, idflush, 2'(st)});
        exp_cnt_q.push_back({m_stall, m_redir});
        if (rst && req && !pce && !redir && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (rst && redir && m_redir != 32'hFFFF_FFFF) m_redir++;
    endtask

    // Monitor: outputs are presented every cycle; check at the falling edge.
    initial begin
        outv_t       exp, got;
        logic [63:0] ec;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                ec  = exp_cnt_q.pop_front();
                got = {imem_req, pc_enable, pc_redirect, if_id_enable, if_id_flush,
                       if_id_valid_in, id_ex_flush, ctrl_state};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got req/pce/redir/ifen/iflush/ival/idfl/st=%b required %b",
                             cyc, got, exp);
                end else if (got[8:7] == 2'b11 && !(imem_ready || got[6])) begin
                    miscompares++;
                    $display("FAIL pc_enable_invariant cycle %0d: got %b", cyc, got);
                end
`ifdef FRONTEND_PERF_CNT_EN
                if ({stall_cycles, redirect_count} !== ec) begin
                    miscompares++;
                    $display("FAIL perf_counters cycle %0d: got %h/%h required %h/%h", cyc,
                             stall_cycles, redirect_count, ec[63:32], ec[31:0]);
                end
`endif
                if (got[4] && got[5]) begin
                    miscompares++;
                    $display("FAIL flush_enable_overlap cycle %0d: got %b", cyc, got);
                end
            end
        end
    end

    initial begin
        bit rst_b;
        rst_n = 0; imem_ready = 0; id_valid = 0; ex_valid = 0; ex_mem_read = 0;
        branch_taken = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        m_fetching = 0; m_stale = 0; m_stall = 0; m_redir = 0;

        // Reset with ready tied 1, then release: req one cycle later.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs2 for one cycle, then normal fetch.
        step(1, 1, 1, 5'd1, 5'd5, 1, 1, 5'd5, 0);
        step(1, 1, 1, 5'd1, 5'd5, 0, 0, 5'd5, 0);
        // ex_rd = 0 never stalls.
        step(1, 1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0);
        // Taken branch with memory ready: stays in FETCH.
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Ready low 3 cycles, branch in cycle 2, stale word on cycle 4.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Branch and load-use together: branch wins.
        step(1, 1, 1, 5'd3, 5'd4, 1, 1, 5'd3, 1);
        // Enter DISCARD then reset; ready pulse during reset ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rst_b = ($urandom_range(0, 199) != 0);
            step(rst_b, $urandom_range(0, 99) < 55, $urandom_range(0, 3) != 0,
                 AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 AW'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frontend_hazard_ctrl.md
Name: frontend_hazard_ctrl

Overview:
Front-end sequencer for the fetch PC register, the IF/ID pipeline register and the ID/EX bubble insertion.
- Owns the instruction-memory request handshake.
- Detects load-use hazards.
- Applies branch redirects and discards in-flight fetches made stale by a redirect.
- Produces every enable, flush and valid strobe for the IF and ID stages.

Parameters:
REG_AW, 5, register-index width for rs1/rs2/rd compares

Ports:
clk  input  1  clock
rst_n  input  1  reset, active-low
imem_req  output  1  fetch request for current PC; held high until imem_ready
imem_ready  input  1  instruction data valid this cycle; completes the request
id_valid  input  1  ID stage holds a valid instruction
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
ex_valid  input  1  EX stage holds a valid instruction
ex_mem_read  input  1  EX instruction is a load
ex_rd  input  REG_AW  EX destination register
branch_taken  input  1  EX resolved a taken branch or jump (already qualified by ex_valid)
pc_enable  output  1  PC register update strobe
pc_redirect  output  1  PC mux selects branch target
if_id_enable  output  1  IF/ID load strobe
if_id_flush  output  1  IF/ID flush (loads NOP, valid=0)
if_id_valid_in  output  1  valid bit presented to IF/ID
id_ex_flush  output  1  bubble into ID/EX
ctrl_state  output  2  current FSM state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. The state register is the only sequential element apart from the optional counters.
- Outputs are combinational from state and inputs (Mealy).
- State encoding: IDLE=0, FETCH=1, DISCARD=2; 3 is unused and recovers to IDLE.
- Reset: state=IDLE. All outputs are 0 while rst_n=0 and in IDLE; imem_ready is ignored in IDLE.
- IDLE: no request issued. Next state is FETCH unconditionally. This gives the first imem_req 1 cycle after reset release.
- Load-use hazard: load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- FETCH: imem_req=1. Rules in priority order; exactly one applies per cycle:
  1. branch_taken: pc_redirect=1, pc_enable=1, if_id_flush=1, id_ex_flush=1, if_id_enable=0. If imem_ready=0, next state is DISCARD; otherwise stay in FETCH and drop the returned word.
  2. load_use: pc_enable=0, if_id_enable=0, id_ex_flush=1. Any word returned this cycle is dropped; the same PC is re-requested next cycle.
  3. imem_ready=1: pc_enable=1, if_id_enable=1, if_id_valid_in=1.
  4. imem_ready=0: pc_enable=0, if_id_enable=1, if_id_valid_in=0, which inserts a bubble into ID.
- DISCARD: imem_req=1, holding the stale transaction.
  - The stale returned word is never loaded. pc_enable=0, if_id_enable=1, if_id_valid_in=0.
  - On imem_ready=1, next state is FETCH, which issues a request for the redirected PC.
  - branch_taken in DISCARD: pc_redirect=1, pc_enable=1, if_id_flush=1, id_ex_flush=1; remain in DISCARD.
- Latency:
  - Taken branch to first fetch of the target: 1 cycle if memory is idle.
  - Taken branch during a memory wait: target fetch starts in the cycle after the stale imem_ready.
  - Load-use stall: exactly 1 bubble cycle per hazard.
- Invariants:
  - if_id_flush and if_id_enable are never both 1.
  - pc_enable=1 implies (imem_ready & no hazard) or pc_redirect.
- Reset mid-wait: returns to IDLE immediately. An imem_ready arriving during or after reset, before FETCH, is ignored.

Optional Feature:
FRONTEND_PERF_CNT_EN
- Defined: adds output ports stall_cycles[31:0] and redirect_count[31:0]. Both are saturating at 32'hFFFFFFFF and reset to 0 asynchronously.
  - stall_cycles increments on each cycle with imem_req & !pc_enable & !pc_redirect.
  - redirect_count increments on each cycle with pc_redirect=1.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds: state localparams FE_IDLE/FE_FETCH/FE_DISCARD, NOP encoding 32'h00000013, REG_AW default.
- One sub-module: frontend_hazard_detect, combinational load-use compare producing load_use. It is reusable by a future forwarding unit.

Test Plan:
- Reset release, imem_ready tied 1 -> imem_req rises 1 cycle after reset release; then pc_enable=1, if_id_valid_in=1 every cycle; ctrl_state 0->1.
- Load-use with ex_mem_read=1, ex_rd=5, id_rs2=5, valids=1, for one cycle -> that cycle pc_enable=0, if_id_enable=0, id_ex_flush=1; next cycle normal fetch. Repeat with ex_rd=0 -> no stall.
- branch_taken with imem_ready=1 -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_enable=1; stays FETCH.
- imem_ready held 0 for 3 cycles, branch_taken in cycle 2 -> enters DISCARD. Returned word on cycle 4 has if_id_valid_in=0; cycle 5 in FETCH, and the next imem_ready loads with valid=1.
- branch_taken and load_use in the same cycle -> branch priority: pc_enable=1, pc_redirect=1, if_id_flush=1.
- rst_n asserted while in DISCARD -> all outputs 0 at once; imem_ready pulse during reset ignored; restart from IDLE.
